// File: rtl/ksa28_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ksa28_share_arbiter
// Function : Round-robin sharing of one external 28-bit adder by two
//            requesters, with tag tracking through the adder's latency.
// Revision : 1.0 - initial release
// ============================================================================
module ksa28_share_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [27:0] req0_a,
  input  logic [27:0] req0_b,
  input  logic        req0_cin,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [27:0] req1_a,
  input  logic [27:0] req1_b,
  input  logic        req1_cin,
  output logic        req1_ready,
  output logic [27:0] add_a,
  output logic [27:0] add_b,
  output logic        add_cin,
  input  logic [27:0] add_sum,
  input  logic        add_cout,
  output logic        res0_valid,
  output logic        res1_valid,
  output logic [27:0] res_sum,
  output logic        res_cout,
  output logic        busy
);

  logic rr;
  logic grant0;
  logic grant1;
  logic iv;
  logic iv_tag;
  logic tail_v;
  logic tail_t;
  logic pipe_busy;

  // rr names the requester that wins when both are valid
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (req0_valid && (!req1_valid || !rr)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr      <= 1'b0;
      iv      <= 1'b0;
      iv_tag  <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
    end else begin
      iv <= grant0 | grant1;
      if (grant0) begin
        add_a   <= req0_a;
        add_b   <= req0_b;
        add_cin <= req0_cin;
        iv_tag  <= 1'b0;
        rr      <= 1'b1;
      end else if (grant1) begin
        add_a   <= req1_a;
        add_b   <= req1_b;
        add_cin <= req1_cin;
        iv_tag  <= 1'b1;
        rr      <= 1'b0;
      end
    end
  end

  generate
    if (LAT == 0) begin : g_lat0
      // Combinational adder: its output belongs to the operation issued now
      assign tail_v    = iv;
      assign tail_t    = iv_tag;
      assign pipe_busy = 1'b0;
    end else begin : g_latn
      logic [LAT-1:0] pipe_v;
      logic [LAT-1:0] pipe_t;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_v <= '0;
          pipe_t <= '0;
        end else begin
          pipe_v[0] <= iv;
          pipe_t[0] <= iv_tag;
          for (int i = 1; i < LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_t[i] <= pipe_t[i-1];
          end
        end
      end

      assign tail_v    = pipe_v[LAT-1];
      assign tail_t    = pipe_t[LAT-1];
      assign pipe_busy = |pipe_v;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
      res_sum    <= '0;
      res_cout   <= 1'b0;
    end else begin
      res0_valid <= tail_v & ~tail_t;
      res1_valid <= tail_v & tail_t;
      if (tail_v) begin
        res_sum  <= add_sum;
        res_cout <= add_cout;
      end
    end
  end

  assign busy = iv | pipe_busy;

endmodule
`default_nettype wire
